// File: rtl/rgb_pkg.sv
// Shared defaults and types for the RGB PWM fader slice.
package rgb_pkg;

    localparam int PWM_BITS_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } fade_state_t;

    typedef struct packed {
        logic [PWM_BITS_DEFAULT-1:0] r;
        logic [PWM_BITS_DEFAULT-1:0] g;
        logic [PWM_BITS_DEFAULT-1:0] b;
    } rgb_duty_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: applied-duty register reloaded on the period boundary,
// and a registered active-low compare against the shared PWM counter.
module pwm_channel
    import rgb_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                load,
    input  logic [PWM_BITS-1:0] duty,
    output logic                led_n
);

    logic [PWM_BITS-1:0] act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act   <= '0;
            led_n <= 1'b1;
        end else begin
            // Compare uses the old duty in the load cycle, so a period never mixes two duties.
            if (load) begin
                act <= duty;
            end
            led_n <= !(pwm_cnt < act);
        end
    end

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB LED fader: accepts a target colour, walks each channel one LSB per
// step interval toward it, and drives three active-low PWM outputs.
module rgb_pwm_fader
    import rgb_pkg::*;
#(
    parameter int PWM_BITS      = PWM_BITS_DEFAULT,
    parameter int STEP_INTERVAL = 20000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                color_valid,
    output logic                color_ready,
    input  logic [PWM_BITS-1:0] color_r,
    input  logic [PWM_BITS-1:0] color_g,
    input  logic [PWM_BITS-1:0] color_b,
    output logic                RGB_R,
    output logic                RGB_G,
    output logic                RGB_B,
    output logic                busy
);

    localparam int SW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_INTERVAL - 1);
    localparam logic [SW-1:0]       STEP_ONE  = SW'(1);
    localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);

    fade_state_t         state;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [SW-1:0]       step_cnt;
    logic [PWM_BITS-1:0] col [3];
    logic [PWM_BITS-1:0] cur [3];
    logic [PWM_BITS-1:0] tgt [3];
    logic [PWM_BITS-1:0] nxt [3];
    logic                any_diff;
    logic                all_done;
    logic [2:0]          led_n;

    assign color_ready = (state == IDLE);
    assign busy        = (state == FADE);

    // nxt is the post-step duty; all_done looks ahead so FADE ends on the final step.
    always_comb begin
        col[0]   = color_r;
        col[1]   = color_g;
        col[2]   = color_b;
        any_diff = 1'b0;
        all_done = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            nxt[i] = cur[i];
            if (cur[i] < tgt[i]) begin
                nxt[i] = cur[i] + DUTY_ONE;
            end else if (cur[i] > tgt[i]) begin
                nxt[i] = cur[i] - DUTY_ONE;
            end
            if (col[i] != cur[i]) begin
                any_diff = 1'b1;
            end
            if (nxt[i] != tgt[i]) begin
                all_done = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + DUTY_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            step_cnt <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                cur[i] <= '0;
                tgt[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (color_valid) begin
                        for (int unsigned i = 0; i < 3; i++) begin
                            tgt[i] <= col[i];
                        end
                        step_cnt <= '0;
                        if (any_diff) begin
                            state <= FADE;
                        end
                    end
                end
                FADE: begin
                    if (step_cnt == STEP_LAST) begin
                        step_cnt <= '0;
                        for (int unsigned i = 0; i < 3; i++) begin
                            cur[i] <= nxt[i];
                        end
                        if (all_done) begin
                            state <= IDLE;
                        end
                    end else begin
                        step_cnt <= step_cnt + STEP_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_ch
        pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .pwm_cnt(pwm_cnt),
            .load   (pwm_cnt == PWM_MAX),
            .duty   (cur[g]),
            .led_n  (led_n[g])
        );
    end

    assign RGB_R = led_n[0];
    assign RGB_G = led_n[1];
    assign RGB_B = led_n[2];

endmodule
